// File: rtl/vga_sync_ctrl.sv
// VGA timing generator: divided pixel tick, pixel/line counters, registered sync and blanking.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_ctrl #(
    parameter int CNT_W   = 12,
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
`ifdef VGA_FRAME_CNT_EN
    output logic             frame_start,
    output logic [15:0]      frame_cnt
`else
    output logic             frame_start
`endif
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VIS + V_FP + V_SYNC);

    generate
        if (H_TOTAL > (2 ** CNT_W) - 1) begin : g_h_total_too_wide
            $error("vga_sync_ctrl: H_TOTAL does not fit in CNT_W bits");
        end
        if (V_TOTAL > (2 ** CNT_W) - 1) begin : g_v_total_too_wide
            $error("vga_sync_ctrl: V_TOTAL does not fit in CNT_W bits");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
            $error("vga_sync_ctrl: CLK_DIV must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_started;
    logic [CNT_W-1:0] r_px_x;
    logic [CNT_W-1:0] r_px_y;
    logic             r_pix_tick;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_start;

    logic             w_div_end;
    logic             w_tick;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_frame_end;
    logic             w_stop;
    logic             w_fs_next;
    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y_next;
    logic             w_hs_next;
    logic             w_vs_next;
    logic             w_vid_next;

    assign w_div_end   = (r_div == DIV_LAST);
    assign w_tick      = (r_state != ST_IDLE) && w_div_end;
    assign w_x_last    = (r_px_x == H_LAST);
    assign w_y_last    = (r_px_y == V_LAST);
    assign w_frame_end = r_started && w_x_last && w_y_last;
    // Leaving on the last pixel of a frame with en low ends the run cleanly.
    assign w_stop      = w_tick && w_frame_end && !en;
    // The first tick after IDLE enters (0,0) rather than advancing past it.
    assign w_fs_next   = w_tick && (!r_started || (w_frame_end && en));

    always_comb begin
        w_x_next = '0;
        w_y_next = '0;
        if (r_started) begin
            if (w_x_last) begin
                w_x_next = '0;
                w_y_next = w_y_last ? '0 : r_px_y + CNT_W'(1);
            end else begin
                w_x_next = r_px_x + CNT_W'(1);
                w_y_next = r_px_y;
            end
        end
    end

    // Decoding the next position keeps sync/blank aligned with px_x/px_y.
    assign w_hs_next  = !((w_x_next >= H_SYNC_LO) && (w_x_next < H_SYNC_HI));
    assign w_vs_next  = !((w_y_next >= V_SYNC_LO) && (w_y_next < V_SYNC_HI));
    assign w_vid_next = (w_x_next < H_VIS_END) && (w_y_next < V_VIS_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_div         <= '0;
            r_started     <= 1'b0;
            r_px_x        <= '0;
            r_px_y        <= '0;
            r_pix_tick    <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_div         <= '0;
                    r_started     <= 1'b0;
                    r_px_x        <= '0;
                    r_px_y        <= '0;
                    r_pix_tick    <= 1'b0;
                    r_hsync       <= 1'b1;
                    r_vsync       <= 1'b1;
                    r_video_on    <= 1'b0;
                    r_frame_start <= 1'b0;
                    if (en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    r_state       <= en ? ST_RUN : ST_DRAIN;
                    r_div         <= w_div_end ? '0 : r_div + DIV_W'(1);
                    r_pix_tick    <= w_div_end;
                    r_frame_start <= w_fs_next;
                    if (w_stop) begin
                        r_state    <= ST_IDLE;
                        r_div      <= '0;
                        r_pix_tick <= 1'b0;
                        r_started  <= 1'b0;
                        r_px_x     <= '0;
                        r_px_y     <= '0;
                        r_hsync    <= 1'b1;
                        r_vsync    <= 1'b1;
                        r_video_on <= 1'b0;
                    end else if (w_div_end) begin
                        r_started  <= 1'b1;
                        r_px_x     <= w_x_next;
                        r_px_y     <= w_y_next;
                        r_hsync    <= w_hs_next;
                        r_vsync    <= w_vs_next;
                        r_video_on <= w_vid_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Survives IDLE; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_fs_next) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign pix_tick    = r_pix_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign px_x        = r_px_x;
    assign px_y        = r_px_y;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl with a shrunken raster; a per-clock reference model feeds a scoreboard queue.
// Checks frame_cnt as well when VGA_FRAME_CNT_EN is defined.
module tb_vga_sync_ctrl;
    localparam int CNT_W   = 8;
    localparam int CLK_DIV = 2;
    localparam int H_VIS   = 8;
    localparam int H_FP    = 2;
    localparam int H_SYNC  = 3;
    localparam int H_BP    = 2;
    localparam int V_VIS   = 6;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 2;
    localparam int HT      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FT      = HT * VT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             pix_tick;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] px_x;
    logic [CNT_W-1:0] px_y;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    always #5 clk = ~clk;

    vga_sync_ctrl #(
        .CNT_W(CNT_W), .CLK_DIV(CLK_DIV),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pix_tick(pix_tick),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .px_x(px_x),
        .px_y(px_y),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
`else
        .frame_start(frame_start)
`endif
    );

    typedef logic [2*CNT_W+4:0] obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: linear pixel index plus clocks elapsed since leaving IDLE.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_pix  = 0;
    int m_fcnt = 0;
    bit m_started = 1'b0;
    bit m_tick = 1'b0;
    bit m_fs = 1'b0;

    int cyc = 0;
    int last_fs = 0;
    int vid_cnt = 0;
    int hs_cnt = 0;
    int vs_cnt = 0;
    bit fs_valid = 1'b0;

    function automatic obs_t pack_dut();
        return {pix_tick, hsync, vsync, video_on, frame_start, px_x, px_y};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_pix = 0; m_started = 1'b0;
            m_tick = 1'b0; m_fs = 1'b0; m_fcnt = 0;
        end else if (m_mode == 0) begin
            m_tick = 1'b0;
            m_fs = 1'b0;
            if (en) begin
                m_mode = 1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            m_tick = ((m_cnt % CLK_DIV) == 0);
            m_fs = 1'b0;
            nxt = en ? 1 : 2;
            if (m_tick) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_pix = 0;
                    m_fs = 1'b1;
                end else if (m_pix == FT - 1) begin
                    m_pix = 0;
                    if (en) begin
                        m_fs = 1'b1;
                    end else begin
                        nxt = 0;
                        m_started = 1'b0;
                        m_tick = 1'b0;
                    end
                end else begin
                    m_pix++;
                end
            end
            m_mode = nxt;
            if (m_fs) m_fcnt = (m_fcnt + 1) % 65536;
        end
    endtask

    task automatic step();
        int x, y;
        bit hs, vs, vid;
        obs_t e;
        model_step();
        x   = m_pix % HT;
        y   = m_pix / HT;
        hs  = !(m_started && x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
        vs  = !(m_started && y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
        vid = m_started && x < H_VIS && y < V_VIS;
        exp_q.push_back({m_tick, hs, vs, vid, m_fs, CNT_W'(x), CNT_W'(y)});
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check("cycle", 32'(pack_dut()), 32'(e));
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
        if (m_mode == 0) fs_valid = 1'b0;
        if (frame_start) begin
            if (fs_valid) begin
                check("frame_period", 32'(cyc - last_fs), 32'(FT * CLK_DIV));
                check("video_ticks", 32'(vid_cnt), 32'(H_VIS * V_VIS));
                check("hsync_low_ticks", 32'(hs_cnt), 32'(H_SYNC * VT));
                check("vsync_low_ticks", 32'(vs_cnt), 32'(V_SYNC * HT));
            end
            fs_valid = 1'b1;
            last_fs = cyc;
            vid_cnt = 0;
            hs_cnt = 0;
            vs_cnt = 0;
        end
        if (pix_tick) begin
            if (video_on) vid_cnt++;
            if (!hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
        end
    endtask

    task automatic run_to(input int x, input int y);
        logic [2*CNT_W-1:0] want;
        want = {CNT_W'(x), CNT_W'(y)};
        for (int n = 0; n < 4000 && {px_x, px_y} !== want; n++) step();
        check("reach_position", 32'({px_x, px_y}), 32'(want));
    endtask

    obs_t idle_vec;

    initial begin
        idle_vec = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CNT_W'(0), CNT_W'(0)};
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) begin
            step();
            check("reset_state", 32'(pack_dut()), 32'(idle_vec));
        end

        rst = 1'b0;
        step();
        step();
        check("pre_first_tick", 32'(pix_tick), 32'(0));
        step();
        check("first_tick_fs", 32'({pix_tick, frame_start}), 32'(2'b11));

        repeat (2 * FT * CLK_DIV) step();

        run_to(5, 3);
        en = 1'b0;
        run_to(HT - 1, VT - 1);
        repeat (CLK_DIV) step();
        check("drain_to_idle", 32'(pack_dut()), 32'(idle_vec));
        repeat (5) step();
        check("idle_hold", 32'(pack_dut()), 32'(idle_vec));

        en = 1'b1;
        run_to(3, 4);
        en = 1'b0;
        run_to(6, 7);
        en = 1'b1;
        run_to(0, 0);
        run_to(2, 1);

        run_to(12, 8);
        rst = 1'b1;
        step();
        check("rst_pulse", 32'(pack_dut()), 32'(idle_vec));
        rst = 1'b0;
        repeat (3) step();
        check("restart_fs", 32'({pix_tick, frame_start, px_x, px_y}),
              32'({1'b1, 1'b1, CNT_W'(0), CNT_W'(0)}));

        repeat (2) begin
            run_to(HT - 1, VT - 1);
            repeat (CLK_DIV) step();
        end
        check("third_frame_fs", 32'(frame_start), 32'(1));
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_three", 32'(frame_cnt), 32'(3));
`endif
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 Parameter CNT_W, default 12: width of the pixel and line counters.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per pixel tick (range 1..16).
REQ-003 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal phase lengths in pixels.
REQ-004 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical phase lengths in lines.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  run request; sampled every clk.
REQ-008 pix_tick  out  1  one-clk pulse per pixel period.
REQ-009 hsync  out  1  horizontal sync, active-low.
REQ-010 vsync  out  1  vertical sync, active-low.
REQ-011 video_on  out  1  high while both counters are in their visible phase.
REQ-012 px_x  out  CNT_W  current pixel column, 0..H_TOTAL-1.
REQ-013 px_y  out  CNT_W  current line, 0..V_TOTAL-1.
REQ-014 frame_start  out  1  one-clk pulse on the pix_tick that moves the position to (0,0).

Function
REQ-015 H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP and V_TOTAL=V_VIS+V_FP+V_SYNC+V_BP, computed at elaboration; both SHALL fit in CNT_W bits (elaboration error otherwise).
REQ-016 Divider counts 0..CLK_DIV-1 only in RUN; pix_tick is high for the clk on which the divider equals CLK_DIV-1; with CLK_DIV=1, pix_tick is high every RUN clk.
REQ-017 Controller FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN: en=1. Counters start at (0,0) and frame_start pulses on the first pix_tick.
- RUN->DRAIN: en=0.
- DRAIN->RUN: en=1 again before the frame ends.
- DRAIN->IDLE: the pix_tick at (H_TOTAL-1,V_TOTAL-1).
REQ-018 On each pix_tick, px_x increments. At H_TOTAL-1 it wraps to 0 and px_y increments. px_y wraps to 0 at V_TOTAL-1 on the same tick that px_x wraps.
REQ-019 Horizontal phases: VISIBLE [0,H_VIS), FRONT [H_VIS,H_VIS+H_FP), SYNC [H_VIS+H_FP,H_VIS+H_FP+H_SYNC), BACK [remainder]. Vertical phases use the same rule on px_y.
REQ-020 hsync is low iff px_x is in horizontal SYNC; vsync is low iff px_y is in vertical SYNC; video_on is high iff px_x<H_VIS and px_y<V_VIS.
REQ-021 All outputs are registered; hsync/vsync/video_on change on the same clk edge as px_x/px_y, with zero lag relative to the position outputs.
REQ-022 In IDLE: px_x=0, px_y=0, hsync=1, vsync=1, video_on=0, pix_tick=0, frame_start=0; the divider is held at 0.
REQ-023 In DRAIN, timing continues unchanged until the frame completes; no partial frame is emitted.

Reset
REQ-024 rst=1 forces the state of REQ-022 (FSM=IDLE) on the next clk edge, from any state and mid-frame, and overrides en.
REQ-025 After rst falls, with en=1 sampled, RUN is entered on the next clk edge.

Configuration
REQ-026 VGA_FRAME_CNT_EN defined: extra output frame_cnt (out, 16 bits) increments on each frame_start, wraps 65535->0, and clears to 0 on rst only (not on IDLE).
REQ-027 VGA_FRAME_CNT_EN undefined: the frame_cnt port and its register are absent; all other behaviour is identical.

Verification
REQ-028 rst=1 for 3 clks, en=1 -> all outputs per REQ-022 during reset; first pix_tick 2 clks after entering RUN; frame_start coincident with it.
REQ-029 Defaults, RUN for one line -> hsync low exactly for px_x 656..751 (96 ticks); line length 800 ticks = 1600 clk.
REQ-030 Full frame -> vsync low for px_y 490..491; frame_start period 420000 pix_ticks = 840000 clk; video_on high for 307200 ticks per frame.
REQ-031 en=0 at (100,200) -> timing continues to (799,524); then IDLE, px_x=px_y=0, hsync=vsync=1; en=1 again at (300,300) in DRAIN -> no discontinuity in px_x/px_y.
REQ-032 rst pulsed for 1 clk at (700,400) -> next clk all outputs per REQ-022; with en=1, restart from (0,0) with frame_start.
REQ-033 VGA_FRAME_CNT_EN, run 3 frames -> frame_cnt=3; preload-style run across 65536 frames (or forced 65535) -> wraps to 0.
